// File: rtl/ctrl_src_arbiter_if.sv
// Control-source arbiter bundle: PC-side and FPGA-side control inputs
// (set level, 5-bit mode, four direction button pulses) plus the
// arbitrated control outputs, the owner select and the switch pulse.
// The arbiter connects through the slave modport; the stimulus side
// connects through the master modport.
interface ctrl_src_arbiter_if;

   logic       iPC_Set;
   logic [4:0] iPC_Mode;
   logic       iPC_Btn_U;
   logic       iPC_Btn_D;
   logic       iPC_Btn_L;
   logic       iPC_Btn_R;

   logic       iFPGA_Set;
   logic [4:0] iFPGA_Mode;
   logic       iFPGA_Btn_U;
   logic       iFPGA_Btn_D;
   logic       iFPGA_Btn_L;
   logic       iFPGA_Btn_R;

   logic       oSel;
   logic       oSet;
   logic [4:0] oMode;
   logic       oBtn_U;
   logic       oBtn_D;
   logic       oBtn_L;
   logic       oBtn_R;
   logic       oSwitch;

   modport master (
      output iPC_Set, iPC_Mode, iPC_Btn_U, iPC_Btn_D, iPC_Btn_L, iPC_Btn_R,
      output iFPGA_Set, iFPGA_Mode, iFPGA_Btn_U, iFPGA_Btn_D, iFPGA_Btn_L, iFPGA_Btn_R,
      input  oSel, oSet, oMode, oBtn_U, oBtn_D, oBtn_L, oBtn_R, oSwitch
   );

   modport slave (
      input  iPC_Set, iPC_Mode, iPC_Btn_U, iPC_Btn_D, iPC_Btn_L, iPC_Btn_R,
      input  iFPGA_Set, iFPGA_Mode, iFPGA_Btn_U, iFPGA_Btn_D, iFPGA_Btn_L, iFPGA_Btn_R,
      output oSel, oSet, oMode, oBtn_U, oBtn_D, oBtn_L, oBtn_R, oSwitch
   );

endinterface

// File: rtl/ctrl_src_arbiter.sv
// ctrl_src_arbiter: decides whether the remote PC or the local FPGA board
// drives the control outputs. Ownership moves to whichever side shows
// activity (button pulse or a change of set/mode), passing through a one
// cycle guard state in which all activity is ignored. The local board wins
// simultaneous activity. Outputs are registered copies of the owner's
// inputs with one cycle of latency; buttons are blanked across a switch.
//
// Optional feature: define ARB_TIMEOUT_EN to return ownership to the FPGA
// after TIMEOUT_CYC cycles without PC activity while the PC owns control.
// Without the macro the inactivity counter is not built at all.
module ctrl_src_arbiter #(
   parameter int unsigned TIMEOUT_CYC = 100_000_000,
   parameter int unsigned CNT_W       = 27
) (
   input logic                iClk,
   input logic                iRst,
   ctrl_src_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {
      FPGA_OWN = 2'd0,
      GRD_PC   = 2'd1,
      PC_OWN   = 2'd2,
      GRD_FPGA = 2'd3
   } state_t;

   state_t     state;
   state_t     next_state;

   // Low during the first cycle after reset so that the previous-value
   // registers can load without a spurious change being reported.
   logic       primed;

   logic       pc_set_q;
   logic [4:0] pc_mode_q;
   logic       fpga_set_q;
   logic [4:0] fpga_mode_q;

   logic [3:0] pc_btn;
   logic [3:0] fpga_btn;
   logic       pc_act;
   logic       fpga_act;
   logic       timeout_hit;

   assign pc_btn   = {bus.iPC_Btn_U, bus.iPC_Btn_D, bus.iPC_Btn_L, bus.iPC_Btn_R};
   assign fpga_btn = {bus.iFPGA_Btn_U, bus.iFPGA_Btn_D, bus.iFPGA_Btn_L, bus.iFPGA_Btn_R};

   // Activity detection: any button pulse, or a set/mode change relative to
   // the value seen in the previous cycle (suppressed right after reset).
   always_comb begin
      pc_act   = (|pc_btn)
               | (primed & ((bus.iPC_Set != pc_set_q) | (bus.iPC_Mode != pc_mode_q)));
      fpga_act = (|fpga_btn)
               | (primed & ((bus.iFPGA_Set != fpga_set_q) | (bus.iFPGA_Mode != fpga_mode_q)));
   end

`ifdef ARB_TIMEOUT_EN
   localparam logic [CNT_W-1:0] CntMax = CNT_W'(TIMEOUT_CYC - 1);

   logic [CNT_W-1:0] idle_cnt;

   assign timeout_hit = (state == PC_OWN) && (idle_cnt == CntMax) && !pc_act;

   // Inactivity counter: restarts on entry to PC ownership and on every PC
   // activity, counts idle PC-owned cycles, and saturates at its limit.
   always_ff @(posedge iClk) begin
      if (iRst) begin
         idle_cnt <= '0;
      end else if ((state != PC_OWN) || (next_state != PC_OWN) || pc_act) begin
         idle_cnt <= '0;
      end else if (idle_cnt != CntMax) begin
         idle_cnt <= idle_cnt + 1'b1;
      end
   end
`else
   assign timeout_hit = 1'b0;
`endif

   // Next-state decision; guard states always advance after one cycle and
   // ignore any activity seen while they are active.
   always_comb begin
      next_state = state;
      case (state)
         FPGA_OWN: begin
            if (pc_act && !fpga_act) begin
               next_state = GRD_PC;
            end
         end
         GRD_PC: begin
            next_state = PC_OWN;
         end
         PC_OWN: begin
            if (fpga_act || timeout_hit) begin
               next_state = GRD_FPGA;
            end
         end
         GRD_FPGA: begin
            next_state = FPGA_OWN;
         end
         default: begin
            next_state = FPGA_OWN;
         end
      endcase
   end

   // State register plus all registered outputs. Outputs follow the owner
   // of the state being entered; buttons are forwarded only while the same
   // owner is retained, so the pulse that triggers a switch and any pulse
   // during the guard cycle are dropped. Set/mode hold through guards.
   always_ff @(posedge iClk) begin
      if (iRst) begin
         state       <= FPGA_OWN;
         primed      <= 1'b0;
         pc_set_q    <= 1'b0;
         pc_mode_q   <= 5'd0;
         fpga_set_q  <= 1'b0;
         fpga_mode_q <= 5'd0;
         bus.oSel    <= 1'b0;
         bus.oSet    <= 1'b0;
         bus.oMode   <= 5'd0;
         bus.oBtn_U  <= 1'b0;
         bus.oBtn_D  <= 1'b0;
         bus.oBtn_L  <= 1'b0;
         bus.oBtn_R  <= 1'b0;
         bus.oSwitch <= 1'b0;
      end else begin
         state       <= next_state;
         primed      <= 1'b1;
         pc_set_q    <= bus.iPC_Set;
         pc_mode_q   <= bus.iPC_Mode;
         fpga_set_q  <= bus.iFPGA_Set;
         fpga_mode_q <= bus.iFPGA_Mode;

         bus.oSel    <= (next_state == PC_OWN) || (next_state == GRD_FPGA);
         bus.oSwitch <= (state == GRD_PC) || (state == GRD_FPGA);

         case (next_state)
            PC_OWN: begin
               bus.oSet  <= bus.iPC_Set;
               bus.oMode <= bus.iPC_Mode;
               if (state == PC_OWN) begin
                  {bus.oBtn_U, bus.oBtn_D, bus.oBtn_L, bus.oBtn_R} <= pc_btn;
               end else begin
                  {bus.oBtn_U, bus.oBtn_D, bus.oBtn_L, bus.oBtn_R} <= 4'b0000;
               end
            end
            FPGA_OWN: begin
               bus.oSet  <= bus.iFPGA_Set;
               bus.oMode <= bus.iFPGA_Mode;
               if (state == FPGA_OWN) begin
                  {bus.oBtn_U, bus.oBtn_D, bus.oBtn_L, bus.oBtn_R} <= fpga_btn;
               end else begin
                  {bus.oBtn_U, bus.oBtn_D, bus.oBtn_L, bus.oBtn_R} <= 4'b0000;
               end
            end
            default: begin
               {bus.oBtn_U, bus.oBtn_D, bus.oBtn_L, bus.oBtn_R} <= 4'b0000;
            end
         endcase
      end
   end

endmodule
